apb_master_bridge: RTL and testbench

CPU-side APB4 initiator. Converts a valid/ready request channel and a valid/ready response channel into APB4 SETUP/ACCESS transfers. Sits between the CPU core and the master port of the APB interconnect. Issues one outstanding transfer at a time and abandons a transfer after a programmable number of wait cycles, returning an error.

---
 rtl/apb_pkg.sv | 35 +++
 rtl/apb_timeout_counter.sv | 57 +++++
 rtl/apb_master_bridge.sv | 130 +++++++++++++
 tb/tb_apb_master_bridge.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_pkg                                                         |
// | Purpose  : Shared types for the APB4 master bridge: FSM state encoding,    |
// |            captured request, returned response and the "no strobes"       |
// |            constant driven on read transfers.                             |
// | Ports    : none (package)                                                 |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } apb_rsp_t;

  localparam logic [3:0] APB_STRB_NONE = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_timeout_counter                                             |
// | Purpose  : Counts ACCESS wait cycles and flags the cycle in which the      |
// |            count reaches TIMEOUT_CYCLES. A limit of 0 disables it.        |
// | Ports    : clk, rst_n  - clock, async active-low reset                     |
// |            clear       - restart the count (asserted in SETUP)            |
// |            enable      - this ACCESS cycle is a wait cycle (pready = 0)   |
// |            expired     - this wait cycle brings the count to the limit    |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A zero limit still needs a legal one-bit register.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating count: stops at LIMIT, never wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is flagged in the wait cycle whose increment reaches LIMIT, so the
  // FSM leaves ACCESS after exactly TIMEOUT_CYCLES wait cycles.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      assign expired = enable && (cnt_q == (LIMIT - CW'(1)));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_master_bridge                                               |
// | Purpose  : CPU-side APB4 initiator. Turns a valid/ready request into one   |
// |            SETUP/ACCESS transfer and returns a valid/ready response.      |
// |            One transfer outstanding; wait states bounded by a timeout.    |
// | Ports    : pclk, preset_n          - clock, async active-low reset        |
// |            req_*                   - request channel (valid/ready)        |
// |            rsp_*                   - response channel (valid/ready)       |
// |            paddr..pstrb            - APB4 master outputs                  |
// |            pready, prdata, pslverr - APB4 completer responses             |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  apb_state_e state_q;
  apb_req_t   req_q;
  apb_rsp_t   rsp_q;
  logic       psel_q;
  logic       penable_q;
  logic       rsp_valid_q;
  logic       timeout_expired;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (pclk),
    .rst_n   (preset_n),
    .clear   (state_q == SETUP),
    .enable  ((state_q == ACCESS) && !pready),
    .expired (timeout_expired)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q.addr  <= req_addr;
            req_q.write <= req_write;
            req_q.wdata <= req_wdata;
            // Reads never carry byte strobes on the bus.
            req_q.strb  <= req_write ? req_strb : APB_STRB_NONE;
            psel_q      <= 1'b1;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // Completion has priority over a timeout landing in the same cycle.
          if (pready) begin
            rsp_q.rdata   <= req_q.write ? 32'h0 : prdata;
            rsp_q.err     <= pslverr;
            rsp_q.timeout <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (timeout_expired) begin
            // Abandon the transfer: the bus is released without pready.
            rsp_q       <= '{rdata: 32'h0, err: 1'b1, timeout: 1'b1};
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by reset so the request channel is closed while reset is held.
  assign req_ready   = (state_q == IDLE) && preset_n;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign paddr       = req_q.addr;
  assign pwrite      = req_q.write;
  assign pwdata      = req_q.wdata;
  assign pstrb       = req_q.strb;
  assign psel        = psel_q;
  assign penable     = penable_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_apb_master_bridge                                            |
// | Purpose  : Self-checking bench for apb_master_bridge (TIMEOUT_CYCLES = 8). |
// |            A transaction-timeline model predicts every output each cycle. |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_apb_master_bridge;

  localparam int TO = 8;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_write;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pslverr;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;

  // Completer configuration for the current transfer.
  int          cfg_wait  = 0;
  logic        cfg_err   = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;

  assign prdata  = cfg_rdata;
  assign pslverr = cfg_err;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Completer: raises pready in ACCESS cycle number cfg_wait (0-based).
  int acc_j = 0;
  always @(negedge pclk) begin
    if (psel && penable) begin
      pready <= (acc_j == cfg_wait);
      acc_j  <= acc_j + 1;
    end else begin
      pready <= 1'b0;
      acc_j  <= 0;
    end
  end

  // Timeline model: m_t counts edges since acceptance. t=1 SETUP,
  // t=2..L+1 ACCESS, t>=L+2 RESP, where L = wait+1 or TO on timeout.
  logic        m_busy = 1'b0;
  int          m_t = 0, m_L = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic        m_write = 0, m_err = 0, m_to = 0;
  logic [3:0]  m_strb = 0;

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      m_busy <= 1'b0; m_t <= 0; m_L <= 0;
      m_addr <= 0; m_wdata <= 0; m_write <= 0; m_strb <= 0;
      m_rdata <= 0; m_err <= 0; m_to <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  <= 1'b1;
        m_t     <= 1;
        m_addr  <= req_addr;
        m_write <= req_write;
        m_wdata <= req_wdata;
        m_strb  <= req_write ? req_strb : 4'h0;
        if (cfg_wait < TO) begin
          m_L     <= cfg_wait + 1;
          m_rdata <= req_write ? 32'h0 : cfg_rdata;
          m_err   <= cfg_err;
          m_to    <= 1'b0;
        end else begin
          m_L     <= TO;
          m_rdata <= 32'h0;
          m_err   <= 1'b1;
          m_to    <= 1'b1;
        end
      end
    end else if ((m_t >= m_L + 2) && rsp_ready) begin
      m_busy <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Per-cycle compare against the model.
  logic chk_en = 1'b0;
  int   n_setup = 0, n_access = 0;
  logic e_rr, e_ps, e_pe, e_rv;

  always @(negedge pclk) begin
    if (chk_en && preset_n) begin
      if (psel && !penable) n_setup++;
      if (psel && penable)  n_access++;
      if (!m_busy) begin
        e_rr = 1; e_ps = 0; e_pe = 0; e_rv = 0;
      end else if (m_t == 1) begin
        e_rr = 0; e_ps = 1; e_pe = 0; e_rv = 0;
      end else if (m_t <= m_L + 1) begin
        e_rr = 0; e_ps = 1; e_pe = 1; e_rv = 0;
      end else begin
        e_rr = 0; e_ps = 0; e_pe = 0; e_rv = 1;
      end
      chk("req_ready", 32'(req_ready), 32'(e_rr));
      chk("psel",      32'(psel),      32'(e_ps));
      chk("penable",   32'(penable),   32'(e_pe));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("paddr",     paddr,          m_addr);
      chk("pwrite",    32'(pwrite),    32'(m_write));
      chk("pwdata",    pwdata,         m_wdata);
      chk("pstrb",     32'(pstrb),     32'(m_strb));
      if (e_rv) begin
        chk("rsp_rdata",   rsp_rdata,          m_rdata);
        chk("rsp_err",     32'(rsp_err),       32'(m_err));
        chk("rsp_timeout", 32'(rsp_timeout),   32'(m_to));
      end
    end
  end

  // One transfer with rsp_ready high; reports latency (negedges after the
  // accept edge until rsp_valid), ACCESS count and the captured response.
  task automatic run_txn(input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int wt, input logic err, input logic [31:0] rd,
                         output int lat, output int nacc, output int nset,
                         output logic [31:0] o_rd, output logic o_err, output logic o_to);
    int guard, base_a, base_s;
    @(negedge pclk);
    cfg_wait = wt; cfg_err = err; cfg_rdata = rd;
    req_addr = addr; req_write = wr; req_wdata = wdata; req_strb = strb;
    req_valid = 1'b1; rsp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge pclk); guard++; end
    chk("accept_bound", 32'(guard < 20), 32'd1);
    base_a = n_access; base_s = n_setup;
    @(negedge pclk);
    // Inputs after the accept edge must not matter.
    req_valid = 1'b0; req_addr = ~addr; req_write = ~wr; req_wdata = ~wdata; req_strb = ~strb;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge pclk); lat++; end
    o_rd = rsp_rdata; o_err = rsp_err; o_to = rsp_timeout;
    nacc = n_access - base_a; nset = n_setup - base_s;
    @(negedge pclk);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  int          lat, nacc, nset, cnt, guard;
  logic [31:0] rd;
  logic        er, tmo;

  initial begin
    preset_n = 1'b0; req_valid = 1'b0; req_addr = 0; req_write = 0;
    req_wdata = 0; req_strb = 0; rsp_ready = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_psel",      32'(psel),      32'd0);
    chk("rst_penable",   32'(penable),   32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr",     paddr,          32'd0);
    chk("rst_pwdata",    pwdata,         32'd0);
    chk("rst_pstrb",     32'(pstrb),     32'd0);
    chk("rst_pwrite",    32'(pwrite),    32'd0);
    chk("rst_rsp",       {rsp_rdata[31:2], rsp_err, rsp_timeout}, 32'd0);
    #1 preset_n = 1'b1; chk_en = 1'b1;
    @(negedge pclk);
    chk("req_ready_first_idle", 32'(req_ready), 32'd1);

    // Zero-wait read.
    run_txn(32'h0002_8004, 1'b0, 32'h1111_2222, 4'hF, 0, 1'b0, 32'hDEAD_BEEF,
            lat, nacc, nset, rd, er, tmo);
    chk("rd0_latency", 32'(lat), 32'd3);
    chk("rd0_setup",   32'(nset), 32'd1);
    chk("rd0_access",  32'(nacc), 32'd1);
    chk("rd0_rdata",   rd, 32'hDEAD_BEEF);
    chk("rd0_err",     32'(er), 32'd0);
    chk("rd0_pstrb",   32'(pstrb), 32'd0);

    // Write with three wait states.
    run_txn(32'h0002_A010, 1'b1, 32'hA5A5_0001, 4'b0011, 3, 1'b0, 32'h1234_5678,
            lat, nacc, nset, rd, er, tmo);
    chk("wr_access",  32'(nacc), 32'd4);
    chk("wr_latency", 32'(lat), 32'd6);
    chk("wr_rdata",   rd, 32'd0);
    chk("wr_paddr",   paddr, 32'h0002_A010);
    chk("wr_pwdata",  pwdata, 32'hA5A5_0001);
    chk("wr_pstrb",   32'(pstrb), 32'h3);

    // Unmapped read answered with pslverr.
    run_txn(32'h1000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b1, 32'hFFFF_0000,
            lat, nacc, nset, rd, er, tmo);
    chk("slverr_err",     32'(er),  32'd1);
    chk("slverr_timeout", 32'(tmo), 32'd0);

    // pready never arrives: abandoned after TO ACCESS cycles.
    run_txn(32'h0002_8008, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'hCAFE_F00D,
            lat, nacc, nset, rd, er, tmo);
    chk("to_access",  32'(nacc), 32'd8);
    chk("to_latency", 32'(lat), 32'd10);
    chk("to_rdata",   rd, 32'd0);
    chk("to_err",     32'(er),  32'd1);
    chk("to_timeout", 32'(tmo), 32'd1);

    // pready in the last allowed ACCESS cycle: completion wins.
    run_txn(32'h0002_800C, 1'b0, 32'h0, 4'h0, 7, 1'b0, 32'h0BEE_F001,
            lat, nacc, nset, rd, er, tmo);
    chk("edge_access",  32'(nacc), 32'd8);
    chk("edge_rdata",   rd, 32'h0BEE_F001);
    chk("edge_err",     32'(er),  32'd0);
    chk("edge_timeout", 32'(tmo), 32'd0);

    // Back-to-back with response backpressure, then reset mid-ACCESS.
    @(negedge pclk);
    cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = 32'h0BAD_F00D;
    req_addr = 32'h0002_8100; req_write = 1'b0; req_wdata = 0; req_strb = 0;
    req_valid = 1'b1; rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge pclk); guard++; end
    @(negedge pclk);
    req_addr = 32'h0002_8200; req_write = 1'b1; req_wdata = 32'h7777_8888; req_strb = 4'hF;
    guard = 0;
    while (!rsp_valid && guard < 40) begin @(negedge pclk); guard++; end
    chk("b2b_first_rsp", 32'(rsp_valid), 32'd1);
    chk("b2b_rdata", rsp_rdata, 32'h0BAD_F00D);
    cfg_wait = 1000;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_req_ready_held", 32'(req_ready), 32'd0);
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    chk("b2b_req_ready_release", 32'(req_ready), 32'd1);
    @(negedge pclk);
    req_valid = 1'b0;
    repeat (2) @(negedge pclk);
    chk("b2b_in_access", 32'({psel, penable}), 32'h3);
    #2 preset_n = 1'b0;
    #1;
    chk("mid_rst_psel",      32'(psel),      32'd0);
    chk("mid_rst_penable",   32'(penable),   32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_paddr",     paddr,          32'd0);
    chk("mid_rst_pwdata",    pwdata,         32'd0);
    chk("mid_rst_pctl",      32'({pwrite, pstrb}), 32'd0);
    @(negedge pclk);
    #2 preset_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge pclk);
      if (rsp_valid) cnt++;
    end
    chk("post_rst_no_rsp", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
